sysmgr_seq: RTL and testbench

Parametrised reset sequencer and sample-rate timebase for the audio clock domain. It takes the 256fs-class clock and the PLL lock indication, holds the domain in reset until lock has been stable for a programmable stretch, and then generates clk_fs, a one-cycle fs strobe and a frame counter. It adds runtime rate selection, lock-loss recovery and frame counting. It sits directly after the PLL; its outputs feed the codec and DSP blocks.

---
 rtl/sysmgr_pkg.sv | 30 +++
 rtl/sync_bit.sv | 29 ++
 rtl/sysmgr_seq.sv | 138 +++++++++++++
 tb/tb_sysmgr_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sysmgr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sysmgr_pkg
// Brief    : Shared types and constants for the sysmgr_seq reset/timebase block
// Revision : 1.0 - initial release
// ============================================================================
package sysmgr_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_X2   = 2'd1;
  localparam logic [1:0] SEL_X4   = 2'd2;

  localparam int DEF_RST_CYCLES_LOG2  = 7;
  localparam int DEF_FS_DIV_LOG2      = 8;
  localparam int DEF_LOCK_SYNC_STAGES = 2;
  localparam int DEF_FRAME_W          = 16;

  // The reserved code 3 falls back to the base rate.
  function automatic logic [1:0] sel_decode(input logic [1:0] sel);
    return (sel == 2'd3) ? SEL_BASE : sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
// Module   : sync_bit
// Brief    : N-stage single-bit synchroniser, asynchronous active-low reset
// Revision : 1.0 - initial release
// ============================================================================
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sysmgr_seq.sv
`default_nettype none
// ============================================================================
// Module   : sysmgr_seq
// Brief    : PLL-lock reset sequencer and fs timebase (clk_fs, strobe, frames).
//            Optional lock-loss statistics: define SYSMGR_SEQ_LOCK_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sysmgr_seq
  import sysmgr_pkg::*;
#(
  parameter int RST_CYCLES_LOG2  = DEF_RST_CYCLES_LOG2,
  parameter int FS_DIV_LOG2      = DEF_FS_DIV_LOG2,
  parameter int LOCK_SYNC_STAGES = DEF_LOCK_SYNC_STAGES,
  parameter int FRAME_W          = DEF_FRAME_W
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               pll_lock_in,
  input  logic [1:0]         div_sel,
  output logic               rst_out,
  output logic               clk_fs,
  output logic               fs_strobe,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [7:0]         lock_loss_cnt
);

  localparam logic [FS_DIV_LOG2-1:0]     C_DIV_ONE     = 1;
  localparam logic [RST_CYCLES_LOG2-1:0] C_STRETCH_ONE = 1;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_lock_s;
  logic [RST_CYCLES_LOG2-1:0] r_stretch_cnt;
  logic [FS_DIV_LOG2-1:0]     r_div_cnt;
  logic [FS_DIV_LOG2-1:0]     w_div_top;
  logic [1:0]                 r_sel_active;
  logic                       r_rst_out;
  logic [FRAME_W-1:0]         r_frame_cnt;
  logic                       w_strobe;
  logic                       w_clk_fs;
  logic                       w_stay_run;
  logic                       w_enter_run;

  sync_bit #(
    .STAGES (LOCK_SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .d     (pll_lock_in),
    .q     (w_lock_s)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= WAIT_LOCK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_LOCK: if (w_lock_s) w_state_nxt = STRETCH;
      STRETCH: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (&r_stretch_cnt) begin
          w_state_nxt = RUN;
        end
      end
      RUN:     if (!w_lock_s) w_state_nxt = WAIT_LOCK;
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  assign w_stay_run  = (r_state == RUN) && (w_state_nxt == RUN);
  assign w_enter_run = (r_state != RUN) && (w_state_nxt == RUN);

  // Terminal count shrinks by one bit per rate step: M-1 = (2^L - 1) >> sel.
  assign w_div_top = {FS_DIV_LOG2{1'b1}} >> r_sel_active;
  assign w_strobe  = (r_state == RUN) && (r_div_cnt == w_div_top);

  always_comb begin
    w_clk_fs = r_div_cnt[FS_DIV_LOG2-1];
    case (r_sel_active)
      SEL_X2:  w_clk_fs = r_div_cnt[FS_DIV_LOG2-2];
      SEL_X4:  w_clk_fs = r_div_cnt[FS_DIV_LOG2-3];
      default: w_clk_fs = r_div_cnt[FS_DIV_LOG2-1];
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_stretch_cnt <= '0;
      r_div_cnt     <= '0;
      r_sel_active  <= SEL_BASE;
      r_rst_out     <= 1'b1;
      r_frame_cnt   <= '0;
    end else begin
      r_stretch_cnt <= ((r_state == STRETCH) && (w_state_nxt == STRETCH))
                       ? r_stretch_cnt + C_STRETCH_ONE : '0;
      r_div_cnt     <= (w_stay_run && !w_strobe) ? r_div_cnt + C_DIV_ONE : '0;
      // Rate changes land only on a period boundary, so clk_fs never glitches.
      if (w_enter_run || w_strobe) begin
        r_sel_active <= sel_decode(div_sel);
      end
      r_rst_out     <= (w_state_nxt != RUN);
      r_frame_cnt   <= w_stay_run ? r_frame_cnt + FRAME_W'(w_strobe) : '0;
    end
  end

`ifdef SYSMGR_SEQ_LOCK_STATS_EN
  logic       w_lock_lost;
  logic [7:0] r_lock_loss_cnt;

  assign w_lock_lost = (r_state == RUN) && (w_state_nxt == WAIT_LOCK);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_lock_loss_cnt <= 8'd0;
    end else if (w_lock_lost && (r_lock_loss_cnt != 8'hFF)) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_lock_loss_cnt;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign rst_out   = r_rst_out;
  assign clk_fs    = w_clk_fs;
  assign fs_strobe = w_strobe;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sysmgr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysmgr_seq
// Brief    : Directed self-checking bench for sysmgr_seq (default parameters)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysmgr_seq;

`ifdef SYSMGR_SEQ_LOCK_STATS_EN
  localparam int EXP_LL1 = 1;
  localparam int EXP_SAT = 255;
`else
  localparam int EXP_LL1 = 0;
  localparam int EXP_SAT = 0;
`endif

  logic        clk_in;
  logic        rst_n_in;
  logic        pll_lock_in;
  logic [1:0]  div_sel;
  logic        rst_out;
  logic        clk_fs;
  logic        fs_strobe;
  logic [15:0] frame_cnt;
  logic [7:0]  lock_loss_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  sysmgr_seq dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .pll_lock_in   (pll_lock_in),
    .div_sel       (div_sel),
    .rst_out       (rst_out),
    .clk_fs        (clk_fs),
    .fs_strobe     (fs_strobe),
    .frame_cnt     (frame_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Walks one fs period from its first cycle through its strobe cycle.
  task automatic run_period(input int chg_at, input logic [1:0] chg_sel,
                            output int len, output int highs);
    len   = 0;
    highs = 0;
    forever begin
      len++;
      if (clk_fs === 1'b1) highs++;
      if (len == chg_at) div_sel = chg_sel;
      if (fs_strobe === 1'b1) break;
      if (len >= 1000) break;
      tick(1);
    end
    tick(1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rst_out"}, rst_out, 1);
    check_eq({tag, "_clk_fs"}, clk_fs, 0);
    check_eq({tag, "_strobe"}, fs_strobe, 0);
    check_eq({tag, "_frame"}, frame_cnt, 0);
    check_eq({tag, "_llc"}, lock_loss_cnt, 0);
  endtask

  int         p_chg_at [9] = '{0, 0, 0, 100, 0, 40, 0, 10, 0};
  logic [1:0] p_chg_sel[9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0};
  int         p_len    [9] = '{256, 256, 256, 256, 128, 128, 64, 64, 256};

  initial begin
    int len;
    int hi;
    int fs_seen;
    int w;
    logic timed_out;

    rst_n_in    = 1'b0;
    pll_lock_in = 1'b1;
    div_sel     = 2'd0;
    tick(2);
    check_reset_state("por");

    // Startup: rst_out falls at edge 131 after release.
    rst_n_in = 1'b1;
    fs_seen  = 0;
    for (int i = 0; i < 130; i++) begin
      tick(1);
      if (clk_fs === 1'b1) fs_seen = 1;
    end
    check_eq("start_rst_hold", rst_out, 1);
    check_eq("start_clkfs_low", fs_seen, 0);
    tick(1);
    check_eq("start_rst_fall", rst_out, 0);
    check_eq("start_frame0", frame_cnt, 0);

    // Rate table: base, mid-period changes to x2, x4 and reserved code 3.
    for (int p = 0; p < 9; p++) begin
      run_period(p_chg_at[p], p_chg_sel[p], len, hi);
      check_eq($sformatf("p%0d_len", p + 1), len, p_len[p]);
      check_eq($sformatf("p%0d_high", p + 1), hi, p_len[p] / 2);
      check_eq($sformatf("p%0d_frame", p + 1), frame_cnt, p + 1);
    end

    // Lock loss during RUN.
    tick(200);
    check_eq("pre_loss_clkfs", clk_fs, 1);
    pll_lock_in = 1'b0;
    tick(3);
    check_eq("loss_rst_out", rst_out, 1);
    check_eq("loss_frame", frame_cnt, 0);
    check_eq("loss_clkfs", clk_fs, 0);
    check_eq("loss_strobe", fs_strobe, 0);
    check_eq("loss_llc", lock_loss_cnt, EXP_LL1);

    // One-cycle lock glitch at stretch cycle 50 restarts the stretch.
    pll_lock_in = 1'b1;
    tick(52);
    pll_lock_in = 1'b0;
    tick(1);
    pll_lock_in = 1'b1;
    tick(130);
    check_eq("restart_rst_hold", rst_out, 1);
    tick(1);
    check_eq("restart_rst_fall", rst_out, 0);
    check_eq("restart_frame0", frame_cnt, 0);
    check_eq("restart_llc", lock_loss_cnt, EXP_LL1);
    run_period(0, 2'd0, len, hi);
    check_eq("restart_len", len, 256);
    check_eq("restart_frame1", frame_cnt, 1);

    // Asynchronous reset mid-RUN, then full resequence.
    tick(150);
    check_eq("pre_rst_clkfs", clk_fs, 1);
    #1 rst_n_in = 1'b0;
    #1 check_reset_state("async");
    #1 rst_n_in = 1'b1;
    tick(130);
    check_eq("reseq_rst_hold", rst_out, 1);
    tick(1);
    check_eq("reseq_rst_fall", rst_out, 0);

    // 300 lock losses to exercise saturation.
    timed_out = 1'b0;
    for (int i = 0; i < 300 && !timed_out; i++) begin
      pll_lock_in = 1'b0;
      tick(3);
      pll_lock_in = 1'b1;
      w = 0;
      while (rst_out !== 1'b0 && w < 200) begin
        tick(1);
        w++;
      end
      if (w >= 200) timed_out = 1'b1;
    end
    check_eq("relock_timeout", timed_out, 0);
    check_eq("llc_saturate", lock_loss_cnt, EXP_SAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
